// File: rtl/stv_stream_packer.sv
`timescale 1ns/1ps
// stv_stream_packer
// Packs RATIO narrow input beats of IN_WIDTH bits into one OUT_WIDTH-bit word.
// Lanes fill little-endian: the first beat of a word lands in the low lane.
// A word closes when its last lane fills, when a beat carries ilast, or when
// flush is raised with a partial word pending. Closed words appear on the
// output register one cycle after the closing input handshake.
//
// Ports:
//   clk, arst_n    clock, asynchronous active-low reset
//   ivalid/iready  input beat handshake, beat data on idata, ilast ends packet
//   flush          request to emit a pending partial word
//   ovalid/oready  output word handshake
//   odata          packed word, unused lanes are zero
//   okeep          per-lane valid mask, contiguous from bit 0
//   olast          word ends a packet
//   busy           partial word pending or output word waiting
module stv_stream_packer #(
  parameter int IN_WIDTH = 8,
  parameter int RATIO    = 4
) (
  input  logic                         clk,
  input  logic                         arst_n,
  input  logic                         ivalid,
  output logic                         iready,
  input  logic [IN_WIDTH-1:0]          idata,
  input  logic                         ilast,
  input  logic                         flush,
  output logic                         ovalid,
  input  logic                         oready,
  output logic [IN_WIDTH*RATIO-1:0]    odata,
  output logic [RATIO-1:0]             okeep,
  output logic                         olast,
  output logic                         busy
);

  localparam int OUT_WIDTH = IN_WIDTH * RATIO;
  localparam int CWIDTH    = $clog2(RATIO);

  logic [CWIDTH-1:0]    lane_cnt;
  logic [OUT_WIDTH-1:0] acc_data;
  logic [RATIO-1:0]     acc_keep;

  logic                 in_hs;
  logic                 out_hs;
  logic                 lane_full;
  logic                 close_word;
  logic [OUT_WIDTH-1:0] merged_data;
  logic [RATIO-1:0]     merged_keep;

  // The output slot is free when empty or when its word leaves this cycle,
  // so a closing beat can refill it without a bubble.
  assign iready = !ovalid || oready;
  assign in_hs  = ivalid && iready;
  assign out_hs = ovalid && oready;
  assign busy   = (lane_cnt != '0) || ovalid;

  // Accumulator view including the beat accepted this cycle, so a closing
  // beat is folded into the word it closes.
  always_comb begin
    merged_data = acc_data;
    merged_keep = acc_keep;
    lane_full   = (lane_cnt == CWIDTH'(RATIO - 1));
    if (in_hs) begin
      merged_data[lane_cnt*IN_WIDTH +: IN_WIDTH] = idata;
      merged_keep[lane_cnt]                      = 1'b1;
    end
  end

  // A beat closes the word on full lane, ilast or flush. A bare flush only
  // closes a non-empty word and only when the output slot can take it, which
  // keeps a stalled output word stable and prevents empty words.
  always_comb begin
    close_word = 1'b0;
    if (in_hs) begin
      close_word = lane_full || ilast || flush;
    end else begin
      close_word = flush && iready && (lane_cnt != '0);
    end
  end

  // Accumulator and output register. On close the accumulator is cleared so
  // the next beat starts at lane 0 with all other lanes zero.
  always_ff @(posedge clk or negedge arst_n) begin
    if (!arst_n) begin
      lane_cnt <= '0;
      acc_data <= '0;
      acc_keep <= '0;
      ovalid   <= 1'b0;
      odata    <= '0;
      okeep    <= '0;
      olast    <= 1'b0;
    end else if (close_word) begin
      odata    <= merged_data;
      okeep    <= merged_keep;
      olast    <= in_hs && ilast;
      ovalid   <= 1'b1;
      acc_data <= '0;
      acc_keep <= '0;
      lane_cnt <= '0;
    end else begin
      if (out_hs) begin
        ovalid <= 1'b0;
      end
      if (in_hs) begin
        acc_data <= merged_data;
        acc_keep <= merged_keep;
        lane_cnt <= lane_cnt + CWIDTH'(1);
      end
    end
  end

endmodule

// File: tb/tb_stv_stream_packer.sv
`timescale 1ns/1ps
// tb_stv_stream_packer
// Directed bench for stv_stream_packer with IN_WIDTH=8, RATIO=4. Inputs are
// driven 1ns after the rising edge and outputs are sampled at the same point,
// so a word closed on an edge is visible on the following sample.
module tb_stv_stream_packer;

  logic        clk;
  logic        arst_n;
  logic        ivalid;
  logic        iready;
  logic [7:0]  idata;
  logic        ilast;
  logic        flush;
  logic        ovalid;
  logic        oready;
  logic [31:0] odata;
  logic [3:0]  okeep;
  logic        olast;
  logic        busy;

  int checkCount;
  int errorCount;

  stv_stream_packer #(.IN_WIDTH(8), .RATIO(4)) dut (
    .clk    (clk),
    .arst_n (arst_n),
    .ivalid (ivalid),
    .iready (iready),
    .idata  (idata),
    .ilast  (ilast),
    .flush  (flush),
    .ovalid (ovalid),
    .oready (oready),
    .odata  (odata),
    .okeep  (okeep),
    .olast  (olast),
    .busy   (busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Counts one comparison and reports it if the observed value differs.
  task automatic checkOutput(input string tag, input logic [31:0] observed,
                             input logic [31:0] expected);
    checkCount++;
    if (observed !== expected) begin
      errorCount++;
      $display("[TB] FAIL %s: got 0x%0h expected 0x%0h", tag, observed, expected);
    end
  endtask

  // Drives one cycle of input, then returns 1ns after the edge with all
  // one-cycle controls dropped.
  task automatic applyStimulus(input logic v, input logic [7:0] d,
                               input logic l, input logic f);
    ivalid = v;
    idata  = d;
    ilast  = l;
    flush  = f;
    @(posedge clk);
    #1;
    ivalid = 1'b0;
    ilast  = 1'b0;
    flush  = 1'b0;
  endtask

  task automatic checkWord(input string tag, input logic [31:0] d,
                           input logic [3:0] k, input logic l);
    checkOutput({tag, ".ovalid"}, {31'd0, ovalid}, 32'd1);
    checkOutput({tag, ".odata"},  odata, d);
    checkOutput({tag, ".okeep"},  {28'd0, okeep}, {28'd0, k});
    checkOutput({tag, ".olast"},  {31'd0, olast}, {31'd0, l});
  endtask

  initial begin
    checkCount = 0;
    errorCount = 0;
    arst_n = 1'b0;
    ivalid = 1'b0;
    idata  = 8'h00;
    ilast  = 1'b0;
    flush  = 1'b0;
    oready = 1'b1;

    // Reset state
    repeat (2) @(posedge clk);
    #1;
    checkOutput("rst.ovalid", {31'd0, ovalid}, 32'd0);
    checkOutput("rst.odata",  odata, 32'd0);
    checkOutput("rst.okeep",  {28'd0, okeep}, 32'd0);
    checkOutput("rst.olast",  {31'd0, olast}, 32'd0);
    checkOutput("rst.busy",   {31'd0, busy}, 32'd0);
    checkOutput("rst.iready", {31'd0, iready}, 32'd1);
    arst_n = 1'b1;
    @(posedge clk);
    #1;

    // Full word back-to-back
    applyStimulus(1'b1, 8'h11, 1'b0, 1'b0);
    applyStimulus(1'b1, 8'h22, 1'b0, 1'b0);
    applyStimulus(1'b1, 8'h33, 1'b0, 1'b0);
    checkOutput("full.partial_ovalid", {31'd0, ovalid}, 32'd0);
    checkOutput("full.partial_busy",   {31'd0, busy}, 32'd1);
    applyStimulus(1'b1, 8'h44, 1'b0, 1'b0);
    checkWord("full", 32'h44332211, 4'b1111, 1'b0);
    applyStimulus(1'b0, 8'h00, 1'b0, 1'b0);
    checkOutput("full.one_cycle", {31'd0, ovalid}, 32'd0);

    // Short packet ended by ilast
    applyStimulus(1'b1, 8'hAA, 1'b0, 1'b0);
    applyStimulus(1'b1, 8'hBB, 1'b1, 1'b0);
    checkWord("ilast", 32'h0000BBAA, 4'b0011, 1'b1);
    applyStimulus(1'b0, 8'h00, 1'b0, 1'b0);
    checkOutput("ilast.idle_busy", {31'd0, busy}, 32'd0);

    // Backpressure: word held while oready is low, input stalled
    oready = 1'b0;
    applyStimulus(1'b1, 8'h01, 1'b1, 1'b0);
    checkWord("stall.first", 32'h00000001, 4'b0001, 1'b1);
    ivalid = 1'b1;
    idata  = 8'h55;
    for (int i = 0; i < 5; i++) begin
      @(posedge clk);
      #1;
      checkOutput("stall.iready", {31'd0, iready}, 32'd0);
      checkWord("stall.hold", 32'h00000001, 4'b0001, 1'b1);
    end
    oready = 1'b1;
    @(posedge clk);
    #1;
    ivalid = 1'b0;
    checkOutput("stall.release_ovalid", {31'd0, ovalid}, 32'd0);
    checkOutput("stall.release_busy",   {31'd0, busy}, 32'd1);
    applyStimulus(1'b0, 8'h00, 1'b0, 1'b1);
    checkWord("stall.lane0", 32'h00000055, 4'b0001, 1'b0);

    // Bare flush of a one-beat partial word
    applyStimulus(1'b1, 8'h7E, 1'b0, 1'b0);
    checkOutput("flush.pending", {31'd0, ovalid}, 32'd0);
    applyStimulus(1'b0, 8'h00, 1'b0, 1'b1);
    checkWord("flush", 32'h0000007E, 4'b0001, 1'b0);

    // Flush with nothing pending produces nothing
    applyStimulus(1'b0, 8'h00, 1'b0, 1'b1);
    applyStimulus(1'b0, 8'h00, 1'b0, 1'b0);
    checkOutput("flush_empty.ovalid", {31'd0, ovalid}, 32'd0);
    checkOutput("flush_empty.busy",   {31'd0, busy}, 32'd0);

    // Flush coincident with an accepted beat includes that beat
    applyStimulus(1'b1, 8'h12, 1'b0, 1'b0);
    applyStimulus(1'b1, 8'h34, 1'b0, 1'b1);
    checkWord("flush_beat", 32'h00003412, 4'b0011, 1'b0);

    // ilast on the lane-filling beat gives exactly one word
    applyStimulus(1'b1, 8'h01, 1'b0, 1'b0);
    applyStimulus(1'b1, 8'h02, 1'b0, 1'b0);
    applyStimulus(1'b1, 8'h03, 1'b0, 1'b0);
    applyStimulus(1'b1, 8'h04, 1'b1, 1'b0);
    checkWord("last_full", 32'h04030201, 4'b1111, 1'b1);
    applyStimulus(1'b0, 8'h00, 1'b0, 1'b0);
    checkOutput("last_full.no_extra", {31'd0, ovalid}, 32'd0);
    checkOutput("last_full.busy",     {31'd0, busy}, 32'd0);

    // Reset mid-word discards pending lanes
    applyStimulus(1'b1, 8'hE1, 1'b0, 1'b0);
    applyStimulus(1'b1, 8'hE2, 1'b0, 1'b0);
    arst_n = 1'b0;
    #1;
    checkOutput("midrst.ovalid", {31'd0, ovalid}, 32'd0);
    checkOutput("midrst.busy",   {31'd0, busy}, 32'd0);
    checkOutput("midrst.iready", {31'd0, iready}, 32'd1);
    @(posedge clk);
    #1;
    arst_n = 1'b1;
    @(posedge clk);
    #1;
    applyStimulus(1'b1, 8'h0A, 1'b0, 1'b0);
    applyStimulus(1'b1, 8'h0B, 1'b0, 1'b0);
    applyStimulus(1'b1, 8'h0C, 1'b0, 1'b0);
    applyStimulus(1'b1, 8'h0D, 1'b0, 1'b0);
    checkWord("postrst", 32'h0D0C0B0A, 4'b1111, 1'b0);

    $display("CHECKS %0d ERRORS %0d", checkCount, errorCount);
    $finish;
  end

endmodule
